// File: rtl/fpga_fabric_top.sv
// Minimal configurable fabric with a single 5-bit up-counter tile.
// Chain 0 holds the tile configuration: EN, the reset pad index and the base pad of the output window.
module fpga_fabric_top #(
    parameter int NUM_PAD   = 2304,
    parameter int NUM_CLK   = 8,
    parameter int NUM_CHAIN = 10,
    parameter int CNT_W     = 5,
    parameter int CFG_W     = 25
) (
    input  logic [0:NUM_CLK-1]   clk,
    input  logic                 global_resetn,
    input  logic                 scan_en,
    input  logic                 scan_mode,
    input  logic                 prog_clock,
    input  logic [0:2]           rwm,
    input  logic [0:NUM_PAD-1]   gfpga_pad_QL_PREIO_A2F,
    output logic [0:NUM_PAD-1]   gfpga_pad_QL_PREIO_F2A,
    output logic [0:NUM_PAD-1]   gfpga_pad_QL_PREIO_F2A_CLK,
    input  logic [0:NUM_CHAIN-1] ccff_head,
    output logic [0:NUM_CHAIN-1] ccff_tail
);
    localparam int PAD_AW = $clog2(NUM_PAD);
    localparam logic [12:0] NUM_PAD_V = 13'(NUM_PAD);

    logic                   clk0;
    logic [CFG_W-1:0]       cfg_q, cfg_d;
    logic [1:NUM_CHAIN-1]   chain_q, chain_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   en;
    logic [11:0]            rst_pad;
    logic [11:0]            out_base;
    logic                   run;
    logic                   rst_hit;
    logic [12:0]            idx;
    logic                   unused_ok;

    assign clk0      = clk[0];
    assign unused_ok = &{1'b0, scan_mode, prog_clock, clk[1:NUM_CLK-1]};

    assign en       = cfg_q[0];
    assign rst_pad  = cfg_q[12:1];
    assign out_base = cfg_q[24:13];
    assign run      = !scan_en && (rwm == 3'b011) && en;

    // A reset pad index beyond the pad bus simply never fires.
    assign rst_hit = ({1'b0, rst_pad} < NUM_PAD_V) && gfpga_pad_QL_PREIO_A2F[rst_pad[PAD_AW-1:0]];

    always_comb begin
        cfg_d   = cfg_q;
        chain_d = chain_q;
        if (scan_en) begin
            cfg_d   = {ccff_head[0], cfg_q[CFG_W-1:1]};
            chain_d = ccff_head[1:NUM_CHAIN-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            if (rst_hit) cnt_d = '0;
            else         cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Configuration storage is deliberately outside the user reset domain.
    always_ff @(posedge clk0) begin
        cfg_q   <= cfg_d;
        chain_q <= chain_d;
    end

    always_ff @(posedge clk0 or negedge global_resetn) begin
        if (!global_resetn) cnt_q <= '0;
        else                cnt_q <= cnt_d;
    end

    always_comb begin
        gfpga_pad_QL_PREIO_F2A = '0;
        idx = '0;
        for (int i = 0; i < CNT_W; i++) begin
            idx = {1'b0, out_base} + 13'(i);
            if (en && (idx < NUM_PAD_V)) begin
                gfpga_pad_QL_PREIO_F2A[idx[PAD_AW-1:0]] = cnt_q[i];
            end
        end
    end

    assign gfpga_pad_QL_PREIO_F2A_CLK = '0;
    assign ccff_tail = {cfg_q[0], chain_q};

endmodule

// File: tb/tb_fpga_fabric_top.sv
// Directed bench for fpga_fabric_top: configuration shifting, counting, resets, freeze and pad-window edges.
module tb_fpga_fabric_top;
    localparam int NUM_PAD = 2304;
    localparam logic [24:0] CFG  = {12'd100,  12'd7,    1'b1};
    localparam logic [24:0] CFG0 = {12'd100,  12'd7,    1'b0};
    localparam logic [24:0] CFGB = {12'd2302, 12'd4000, 1'b1};

    typedef struct {
        logic [0:2] rwm;
        logic       rst;
        logic [4:0] exp;
    } vec_t;

    logic               clk0;
    logic [0:7]         clk;
    logic               global_resetn, scan_en, scan_mode, prog_clock;
    logic [0:2]         rwm;
    logic [0:NUM_PAD-1] a2f, f2a, f2a_clk;
    logic [0:9]         head, tail;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_cnt;
    vec_t vecs[$];

    assign clk = {clk0, 7'b0};

    fpga_fabric_top dut (
        .clk                        (clk),
        .global_resetn              (global_resetn),
        .scan_en                    (scan_en),
        .scan_mode                  (scan_mode),
        .prog_clock                 (prog_clock),
        .rwm                        (rwm),
        .gfpga_pad_QL_PREIO_A2F     (a2f),
        .gfpga_pad_QL_PREIO_F2A     (f2a),
        .gfpga_pad_QL_PREIO_F2A_CLK (f2a_clk),
        .ccff_head                  (head),
        .ccff_tail                  (tail)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        @(negedge clk0);
    endtask

    function automatic logic [31:0] get_cnt(input int base);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            if (base + i < NUM_PAD) r[i] = f2a[base + i];
        return r;
    endfunction

    function automatic logic [31:0] ones_outside(input int base);
        logic [31:0] n;
        n = '0;
        for (int p = 0; p < NUM_PAD; p++)
            if ((p < base || p >= base + 5) && f2a[p] !== 1'b0) n++;
        return n;
    endfunction

    function automatic logic [31:0] clk_ones();
        logic [31:0] n;
        n = '0;
        for (int p = 0; p < NUM_PAD; p++)
            if (f2a_clk[p] !== 1'b0) n++;
        return n;
    endfunction

    // Shifts v in LSB first; when chk is set, tail[0] must replay prev in order.
    task automatic shift_cfg(input logic [24:0] v, input logic [24:0] prev, input bit chk);
        logic [0:9] h;
        for (int i = 0; i < 25; i++) begin
            if (chk) check("tail0_replay", {31'b0, tail[0]}, {31'b0, prev[i]});
            h = 10'($urandom_range(0, 1023));
            h[0] = v[i];
            head = h;
            scan_en = 1'b1;
            tick();
            check("tail_1_9", {22'b0, tail[1:9]}, {22'b0, h[1:9]});
        end
        scan_en = 1'b0;
        head = '0;
    endtask

    initial begin
        global_resetn = 1'b0;
        scan_en = 1'b0;
        scan_mode = 1'b0;
        prog_clock = 1'b0;
        rwm = 3'b000;
        a2f = '0;
        head = '0;
        repeat (2) tick();

        shift_cfg(CFG, '0, 1'b0);
        check("cfg_load", {7'b0, dut.cfg_q}, {7'b0, CFG});
        check("reset_cnt", get_cnt(100), 0);
        check("reset_rest", ones_outside(100), 0);
        check("f2a_clk", clk_ones(), 0);
        shift_cfg(CFG, CFG, 1'b1);
        check("cfg_reload", {7'b0, dut.cfg_q}, {7'b0, CFG});

        rwm = 3'b011;
        a2f[7] = 1'b1;
        repeat (2) tick();
        a2f[7] = 1'b0;
        repeat (8) tick();
        global_resetn = 1'b1;
        check("release_cnt", get_cnt(100), 0);

        for (int k = 1; k <= 9; k++) vecs.push_back('{3'b011, 1'b0, 5'(k)});
        vecs.push_back('{3'b011, 1'b1, 5'd0});
        vecs.push_back('{3'b011, 1'b0, 5'd1});
        vecs.push_back('{3'b011, 1'b0, 5'd2});
        vecs.push_back('{3'b000, 1'b0, 5'd2});
        vecs.push_back('{3'b000, 1'b1, 5'd2});
        vecs.push_back('{3'b111, 1'b0, 5'd2});
        vecs.push_back('{3'b010, 1'b0, 5'd2});
        vecs.push_back('{3'b011, 1'b0, 5'd3});
        vecs.push_back('{3'b011, 1'b1, 5'd0});
        for (int k = 1; k <= 15; k++) vecs.push_back('{3'b011, 1'b0, 5'(k)});

        foreach (vecs[i]) begin
            rwm = vecs[i].rwm;
            a2f[7] = vecs[i].rst;
            tick();
            check($sformatf("vec%0d_cnt", i), get_cnt(100), {27'b0, vecs[i].exp});
            check($sformatf("vec%0d_rest", i), ones_outside(100), 0);
        end
        rwm = 3'b011;
        a2f[7] = 1'b0;

        // Wrap: from 0, 33 enabled edges pass through 31 -> 0 -> 1.
        a2f[7] = 1'b1;
        tick();
        a2f[7] = 1'b0;
        check("wrap_start", get_cnt(100), 0);
        exp_cnt = 5'd0;
        for (int k = 0; k < 33; k++) begin
            tick();
            exp_cnt = exp_cnt + 5'd1;
            check("wrap_cnt", get_cnt(100), {27'b0, exp_cnt});
        end

        repeat (11) begin
            tick();
            exp_cnt = exp_cnt + 5'd1;
        end
        check("pre_async", get_cnt(100), 12);
        #2 global_resetn = 1'b0;
        #1;
        check("async_cnt", get_cnt(100), 0);
        check("async_rest", ones_outside(100), 0);
        check("async_cfg", {7'b0, dut.cfg_q}, {7'b0, CFG});
        @(negedge clk0);
        global_resetn = 1'b1;
        exp_cnt = 5'd0;
        tick();
        exp_cnt = exp_cnt + 5'd1;
        check("after_async", get_cnt(100), {27'b0, exp_cnt});

        shift_cfg(CFG, CFG, 1'b1);
        check("scan_hold", get_cnt(100), {27'b0, exp_cnt});

        shift_cfg(CFG0, CFG, 1'b1);
        check("en0_all", ones_outside(-10), 0);
        repeat (3) tick();
        check("en0_hold_all", ones_outside(-10), 0);
        shift_cfg(CFG, CFG0, 1'b1);
        check("en0_held_cnt", get_cnt(100), {27'b0, exp_cnt});
        tick();
        exp_cnt = exp_cnt + 5'd1;
        check("en1_resume", get_cnt(100), {27'b0, exp_cnt});

        shift_cfg(CFGB, CFG, 1'b1);
        a2f = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_cnt = exp_cnt + 5'd1;
            check("edge_window", get_cnt(2302), {30'b0, exp_cnt[1:0]});
            check("edge_rest", ones_outside(2302), 0);
        end
        check("f2a_clk_end", clk_ones(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
